serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: sums DIGIT bits per clock over WIDTH/DIGIT cycles, LSB slice first.
// Define SERIAL_ADDER_SUB_EN to enable the subtract path (A - B - CIN) selected by i_sub.
module serial_adder #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DIGIT = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_shuma,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW    = DIGIT + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic [IDX_W-1:0] w_base;
    logic [SW-1:0]    w_slice;
    logic [WIDTH-1:0] w_sum_next;

    // Subtraction is folded in at capture: r_b holds the effective operand, r_carry the effective carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in   = i_sub ? ~i_b : i_b;
    assign w_cin_in = i_sub ? ~i_cin : i_cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = i_sub;
    assign w_b_in       = i_b;
    assign w_cin_in     = i_cin;
`endif

    // One DIGIT-wide slice add, chained through the registered carry.
    always_comb begin
        w_base     = IDX_W'(r_cnt) * IDX_W'(DIGIT);
        w_slice    = {1'b0, r_a[w_base +: DIGIT]} + {1'b0, r_b[w_base +: DIGIT]} + SW'(r_carry);
        w_sum_next = r_sum;
        w_sum_next[w_base +: DIGIT] = w_slice[DIGIT-1:0];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_shuma <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice[DIGIT];
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_shuma <= w_sum_next;
                        o_cout  <= w_slice[DIGIT];
                        o_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: table-driven vectors through a scoreboard plus multi-cycle corner sequences.
module tb_serial_adder;
    localparam int unsigned W = 24;
    localparam int N = 6;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk, rst, start, s1, s24, cin, sub;
    logic [W-1:0] a, b;
    logic busy, done, cout, ovf;
    logic [W-1:0] shuma;
    logic d1_busy, d1_done, d1_cout, d1_ovf;
    logic [W-1:0] d1_sum;
    logic d24_busy, d24_done, d24_cout, d24_ovf;
    logic [W-1:0] d24_sum;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];

    serial_adder #(.WIDTH(W), .DIGIT(4)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy), .o_done(done), .o_shuma(shuma), .o_cout(cout), .o_ovf(ovf));
    serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .i_clock(clk), .i_reset(rst), .i_start(s1), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(d1_busy), .o_done(d1_done), .o_shuma(d1_sum), .o_cout(d1_cout), .o_ovf(d1_ovf));
    serial_adder #(.WIDTH(W), .DIGIT(24)) u_d24 (
        .i_clock(clk), .i_reset(rst), .i_start(s24), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(d24_busy), .o_done(d24_done), .o_shuma(d24_sum), .o_cout(d24_cout), .o_ovf(d24_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Arithmetic reference: whole-word add with optional subtract.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        logic [W-1:0] be;
        logic         c;
        logic [W:0]   s;
        exp_t         e;
        be = mb;
        c  = mcin;
        if (SUB_EN && msub) begin
            be = ~mb;
            c  = ~mcin;
        end
        s = {1'b0, ma} + {1'b0, be} + (W+1)'(c);
        e.sum      = s[W-1:0];
        e.cout     = s[W];
        e.ovf      = (ma[W-1] == be[W-1]) && (s[W-1] != ma[W-1]);
        e.done_cyc = 0;
        return e;
    endfunction

    // Scoreboard consumer: every DONE must match the oldest expected result and its cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sum", 32'(shuma), 32'(mon_e.sum));
                check("cout", 32'(cout), 32'(mon_e.cout));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input bit accept, input exp_t e);
        exp_t ee;
        ee = e;
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        if (accept) begin
            ee.done_cyc = cyc + 1 + N;
            sb.push_back(ee);
        end
        step();
        start = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_idle(output int busy_n);
        bit fin;
        busy_n = 0;
        fin    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!fin) begin
                if (sb.size() == 0) fin = 1'b1;
                else begin
                    if (busy === 1'b1) busy_n++;
                    step();
                end
            end
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no DONE, expected one within 64 cycles");
            sb.delete();
        end
    endtask

    task automatic run_alt(input bit sel, input int n_exp);
        int lat;
        int bc;
        a = 24'hFFFFFF; b = 24'h000001; cin = 1'b0; sub = 1'b0;
        if (sel) s24 = 1'b1;
        else     s1  = 1'b1;
        step();
        s1 = 1'b0; s24 = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        lat = 0;
        bc  = 0;
        while (!((sel ? d24_done : d1_done) === 1'b1) && lat < 40) begin
            if ((sel ? d24_busy : d1_busy) === 1'b1) bc++;
            step();
            lat++;
        end
        check(sel ? "n1_latency" : "n24_latency", 32'(lat), 32'(n_exp));
        check(sel ? "n1_busy" : "n24_busy", 32'(bc), 32'(n_exp));
        check(sel ? "n1_sum" : "n24_sum", 32'(sel ? d24_sum : d1_sum), 32'h000000);
        check(sel ? "n1_cout" : "n24_cout", 32'(sel ? d24_cout : d1_cout), 32'd1);
        check(sel ? "n1_ovf" : "n24_ovf", 32'(sel ? d24_ovf : d1_ovf), 32'd0);
        step();
    endtask

    initial begin
        int   busy_n;
        exp_t e;
        rst = 1'b1; start = 1'b0; s1 = 1'b0; s24 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        vecs[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[1] = '{24'h7FFFFF, 24'h000000, 1'b1, 1'b0, 24'h800000, 1'b0, 1'b1};
        vecs[2] = '{24'h000005, 24'h000007, 1'b0, 1'b1,
                    SUB_EN ? 24'hFFFFFE : 24'h00000C, 1'b0, 1'b0};
        vecs[3] = '{24'h123456, 24'h654321, 1'b0, 1'b0, 24'h777777, 1'b0, 1'b0};
        vecs[4] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{24'h0F0F0F, 24'h00F0F0, 1'b1, 1'b0, 24'h100000, 1'b0, 1'b0};
        vecs[7] = '{24'h800000, 24'h000001, 1'b0, 1'b1,
                    SUB_EN ? 24'h7FFFFF : 24'h800001, SUB_EN, SUB_EN};
        vecs[8] = '{24'h00000A, 24'h000003, 1'b1, 1'b1,
                    SUB_EN ? 24'h000006 : 24'h00000E, SUB_EN, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(shuma), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            e.sum  = vecs[i].sum;
            e.cout = vecs[i].cout;
            e.ovf  = vecs[i].ovf;
            e.done_cyc = 0;
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, e);
            wait_idle(busy_n);
            check("busy_cycles", 32'(busy_n), 32'(N));
        end

        // START during RUN is ignored; START in the DONE cycle is accepted.
        issue(24'h000001, 24'h000002, 1'b0, 1'b0, 1'b1, model(24'h000001, 24'h000002, 1'b0, 1'b0));
        step(); step();
        issue(24'h000100, 24'h000100, 1'b0, 1'b0, 1'b0, model(24'h000100, 24'h000100, 1'b0, 1'b0));
        step(); step(); step();
        check("done_cycle_pulse", 32'(done), 32'd1);
        check("busy_in_done_cycle", 32'(busy), 32'd0);
        issue(24'h000010, 24'h000020, 1'b0, 1'b0, 1'b1, model(24'h000010, 24'h000020, 1'b0, 1'b0));
        wait_idle(busy_n);
        check("b2b_busy", 32'(busy_n), 32'(N));

        // Reset in cycle 4 of RUN, with a simultaneous START that must be dropped.
        issue(24'h123456, 24'h111111, 1'b0, 1'b0, 1'b0, model(24'h123456, 24'h111111, 1'b0, 1'b0));
        step(); step(); step();
        rst = 1'b1; start = 1'b1; a = 24'hABCDEF; b = 24'h000001;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(shuma), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0; start = 1'b0;
        busy_n = 0;
        repeat (8) begin
            if (busy !== 1'b0) busy_n++;
            step();
        end
        check("idle_after_reset", 32'(busy_n), 32'd0);
        issue(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 1'b1, model(24'hFFFFFF, 24'h000001, 1'b0, 1'b0));
        wait_idle(busy_n);
        check("post_reset_busy", 32'(busy_n), 32'(N));

        run_alt(1'b0, 24);
        run_alt(1'b1, 1);

        repeat (4) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
